// File: rtl/chunked_adder_if.sv
// chunked_adder_if: command/result bundle for chunked_adder.
//   Command side : in_valid, in_ready, a, b, sub, acc_en, acc_clr
//   Result side  : out_valid, out_ready, y (WIDTH+1 bits, top bit carry/borrow)
//   Status       : busy, dbg_state (FSM encoding), dbg_acc (accumulator)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its payload steady until that
// edge; ready may be high without valid and carries no obligation.
// acc_clr is a plain level strobe and is not qualified by in_valid.
interface chunked_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y;
  logic             busy;
  logic [1:0]       dbg_state;
  logic [WIDTH-1:0] dbg_acc;

  modport master (
    output in_valid, a, b, sub, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, y, busy, dbg_state, dbg_acc
  );

  modport slave (
    input  in_valid, a, b, sub, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, y, busy, dbg_state, dbg_acc
  );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, holding the inter-chunk carry in a register so the combinational
// carry chain is only CHUNK bits long.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : chunked_adder_if.slave (command in, result out, status/debug)
// Optional accumulate mode uses an internal running sum as operand A and
// writes the low WIDTH result bits back into it.
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  chunked_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_adder: CHUNK must divide WIDTH and WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               sub_q, sub_d;
  logic               acc_en_q, acc_en_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]     y_q, y_d;

  logic [CHUNK:0]     chunk_sum;
  logic [31:0]        lsb;
  logic               last_chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      sub_q    <= 1'b0;
      acc_en_q <= 1'b0;
      acc_q    <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      sub_q    <= sub_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    sub_d      = sub_q;
    acc_en_d   = acc_en_q;
    acc_d      = acc_q;
    y_d        = y_q;

    lsb        = 32'(idx_q) * 32'(CHUNK);
    chunk_sum  = {1'b0, opa_q[lsb +: CHUNK]} + {1'b0, opb_q[lsb +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // A clear arriving with an accumulate command zeroes operand A too,
          // so "clear and add" in one command starts from zero.
          opa_d    = bus.acc_en ? (bus.acc_clr ? '0 : acc_q) : bus.a;
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          opb_d    = bus.sub ? ~bus.b : bus.b;
          carry_d  = bus.sub;
          sub_d    = bus.sub;
          acc_en_d = bus.acc_en;
          idx_d    = '0;
          res_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        res_d[lsb +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d             = chunk_sum[CHUNK];
        if (last_chunk) begin
          // For subtraction a missing final carry means a borrow.
          y_d     = {sub_q ? ~chunk_sum[CHUNK] : chunk_sum[CHUNK], res_d};
          idx_d   = '0;
          state_d = S_DONE;
          if (acc_en_q) begin
            acc_d = res_d;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear has priority over any same-cycle write-back.
    if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.y         = y_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_acc   = acc_q;

endmodule
